mure_retire_serializer: RTL

Parametrised retirement-bundle buffer and serializer between the CPU commit stage and the trace encoder front end. Each cycle it captures one bundle of up to NRET retired instructions plus bundle-level exception/interrupt/eret flags into a DEPTH-entry queue. It then emits the valid slots one per cycle in ascending port order over a valid/ready handshake, skipping invalid slots with no bubbles. Overflow is detected and reported sticky; a synchronous flush empties the queue.

---
 rtl/mure_retire_serializer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mure_retire_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mure_retire_serializer                                                   |
// | Buffers commit bundles; emits their valid slots one beat per cycle.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mure_retire_serializer #(
  parameter int NRET     = 2,
  parameter int DEPTH    = 8,
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic [NRET-1:0]           valid_i,
  input  logic [NRET*XLEN-1:0]      pc_i,
  input  logic [NRET*INST_LEN-1:0]  inst_data_i,
  input  logic [NRET-1:0]           compressed_i,
  input  logic                      exception_i,
  input  logic                      interrupt_i,
  input  logic                      eret_i,
  output logic                      full_o,
  output logic                      overflow_o,
  output logic [$clog2(DEPTH):0]    usage_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [$clog2(NRET)-1:0]   port_o,
  output logic [XLEN-1:0]           pc_o,
  output logic [INST_LEN-1:0]       inst_data_o,
  output logic                      compressed_o,
  output logic                      exception_o,
  output logic                      interrupt_o,
  output logic                      eret_o,
  output logic                      last_o
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_USE_W  = c_PTR_W + 1;
  localparam int c_PORT_W = $clog2(NRET);

  logic [NRET-1:0]                r_valid_mem [DEPTH];
  logic [NRET-1:0][XLEN-1:0]      r_pc_mem    [DEPTH];
  logic [NRET-1:0][INST_LEN-1:0]  r_inst_mem  [DEPTH];
  logic [NRET-1:0]                r_cmp_mem   [DEPTH];
  logic [2:0]                     r_flag_mem  [DEPTH];

  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_USE_W-1:0]  r_usage;
  logic [NRET-1:0]     r_served;
  logic                r_overflow;

  logic                w_qualify;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_beat;
  logic [NRET-1:0]     w_rem;
  logic [NRET-1:0]     w_sel;
  logic [c_PORT_W-1:0] w_idx;
  logic                w_last;
  logic [2:0]          w_head_flags;

  assign w_qualify = |valid_i;
  assign w_full    = (r_usage == c_USE_W'(DEPTH));
  assign w_empty   = (r_usage == '0);
  assign w_push    = w_qualify && !w_full && !flush_i;
  assign w_beat    = !w_empty && ready_i && !flush_i;
  assign w_pop     = w_beat && w_last;

  // Remaining slots of the head bundle; the lowest one is the current beat.
  assign w_rem  = r_valid_mem[r_rd_ptr] & ~r_served;
  assign w_sel  = w_rem & (~w_rem + {{(NRET-1){1'b0}}, 1'b1});
  assign w_last = ~|(w_rem & ~w_sel);

  always_comb begin
    w_idx = '0;
    for (int i = NRET - 1; i >= 0; i--) begin
      if (w_rem[i]) w_idx = c_PORT_W'(i);
    end
  end

  // Payload storage needs no reset: it is only observed when the queue is non-empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_valid_mem[r_wr_ptr] <= valid_i;
      r_pc_mem[r_wr_ptr]    <= pc_i;
      r_inst_mem[r_wr_ptr]  <= inst_data_i;
      r_cmp_mem[r_wr_ptr]   <= compressed_i;
      r_flag_mem[r_wr_ptr]  <= {exception_i, interrupt_i, eret_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_usage    <= '0;
      r_served   <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
      r_served <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_usage <= r_usage + 1'b1;
        2'b01:   r_usage <= r_usage - 1'b1;
        default: r_usage <= r_usage;
      endcase
      if (w_pop)       r_served <= '0;
      else if (w_beat) r_served <= r_served | w_sel;
      // A same-cycle pop does not make room for a bundle arriving while full.
      if (w_qualify && w_full) r_overflow <= 1'b1;
    end
  end

  assign w_head_flags = r_flag_mem[r_rd_ptr];

  assign full_o       = w_full;
  assign overflow_o   = r_overflow;
  assign usage_o      = r_usage;
  assign valid_o      = !w_empty;
  assign port_o       = valid_o ? w_idx : '0;
  assign pc_o         = valid_o ? r_pc_mem[r_rd_ptr][w_idx] : '0;
  assign inst_data_o  = valid_o ? r_inst_mem[r_rd_ptr][w_idx] : '0;
  assign compressed_o = valid_o && r_cmp_mem[r_rd_ptr][w_idx];
  assign last_o       = valid_o && w_last;
  assign exception_o  = last_o && w_head_flags[2];
  assign interrupt_o  = last_o && w_head_flags[1];
  assign eret_o       = last_o && w_head_flags[0];

endmodule
`default_nettype wire
